// File: rtl/config_loader_pkg.sv
// Shared definitions for the serial configuration loader.
//   NWORDS / WORDW / SYNC : frame geometry and sync byte defaults
//   word-index constants  : first slot of each configuration region
//   state_t               : loader FSM states
package config_loader_pkg;

  localparam int         NWORDS = 15;
  localparam int         WORDW  = 32;
  localparam logic [7:0] SYNC   = 8'hA5;

  // Word slots within a frame: LUT words, mux-control words, switch-box words.
  localparam logic [3:0] ADD0 = 4'd0;
  localparam logic [3:0] ADD1 = 4'd2;
  localparam logic [3:0] ADDC = 4'd4;
  localparam logic [3:0] MUX  = 4'd6;
  localparam logic [3:0] MUXS = 4'd8;
  localparam logic [3:0] REGC = 4'd10;
  localparam logic [3:0] SB0  = 4'd12;
  localparam logic [3:0] SB12 = 4'd13;
  localparam logic [3:0] SB3  = 4'd14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LOAD,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/cfg_shifter.sv
// Serial-in, MSB-first shift register with a 5-bit bit counter.
//   clock, reset_n : clock / async active-low reset
//   clear          : zero register and counter (has priority over shift_en)
//   shift_en       : accept bit_in this cycle
//   bit_in         : serial data
//   word           : current register contents
//   word_next      : contents after shifting bit_in in
//   word_done      : combinational; this accepted bit completes a word
module cfg_shifter #(
  parameter int WORDW = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WORDW-1:0] word,
  output logic [WORDW-1:0] word_next,
  output logic             word_done
);

  logic [4:0] bitcnt;

  always_comb begin
    word_next = {word[WORDW-2:0], bit_in};
    word_done = shift_en && (bitcnt == 5'(WORDW-1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      word   <= '0;
      bitcnt <= '0;
    end else if (clear) begin
      word   <= '0;
      bitcnt <= '0;
    end else if (shift_en) begin
      word   <= word_next;
      bitcnt <= bitcnt + 5'd1;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Serial configuration frame loader: sync byte, NWORDS words, XOR checksum.
//   clock, reset_n       : clock / async active-low reset
//   cfg_start            : begin/restart a frame (wins over a same-cycle bit)
//   cfg_bit, cfg_valid   : serial data, accepted when cfg_valid && cfg_ready
//   cfg_ready            : high in SYNC and LOAD
//   wr_en/wr_addr/wr_data: one-cycle word write into the fabric
//   cfg_mode             : fabric held in configuration (low only in DONE)
//   done / error         : frame loaded OK / checksum mismatch
module config_loader #(
  parameter int         NWORDS = config_loader_pkg::NWORDS,
  parameter int         WORDW  = config_loader_pkg::WORDW,
  parameter logic [7:0] SYNC   = config_loader_pkg::SYNC
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_start,
  input  logic             cfg_bit,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             wr_en,
  output logic [3:0]       wr_addr,
  output logic [WORDW-1:0] wr_data,
  output logic             cfg_mode,
  output logic             done,
  output logic             error
);

  import config_loader_pkg::*;

  state_t           state_q, state_d;
  logic [WORDW-1:0] sh_word, sh_next;
  logic             sh_done;
  logic             accept, sync_hit, shift_clear, load_word, last_word;
  logic [3:0]       wcnt;
  logic [WORDW-1:0] acc;

  always_comb begin
    accept      = cfg_ready && cfg_valid && !cfg_start;
    // Sync match looks at the window including the bit being accepted, so
    // LOAD starts on the very next cycle with a cleared shifter.
    sync_hit    = (state_q == S_SYNC) && accept && (sh_next[7:0] == SYNC);
    shift_clear = cfg_start || sync_hit;
    load_word   = (state_q == S_LOAD) && sh_done;
    last_word   = (wcnt == 4'(NWORDS));
  end

  cfg_shifter #(.WORDW(WORDW)) u_shifter (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (shift_clear),
    .shift_en  (accept),
    .bit_in    (cfg_bit),
    .word      (sh_word),
    .word_next (sh_next),
    .word_done (sh_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cfg_start) begin
      state_d = S_SYNC;
    end else begin
      unique case (state_q)
        S_SYNC:  if (sync_hit) state_d = S_LOAD;
        S_LOAD:  if (load_word && last_word) state_d = S_CHECK;
        // Shifter is stalled (not ready) in CHECK, so it still holds the checksum.
        S_CHECK: state_d = (sh_word == acc) ? S_DONE : S_ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    cfg_ready = (state_q == S_SYNC) || (state_q == S_LOAD);
    cfg_mode  = (state_q != S_DONE);
    done      = (state_q == S_DONE);
    error     = (state_q == S_ERR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wcnt    <= '0;
      acc     <= '0;
    end else begin
      wr_en <= 1'b0;
      if (cfg_start) begin
        wcnt <= '0;
        acc  <= '0;
      end else if (load_word && !last_word) begin
        wr_en   <= 1'b1;
        wr_addr <= wcnt;
        wr_data <= sh_next;
        acc     <= acc ^ sh_next;
        wcnt    <= wcnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;

  localparam int NW = 15;
  localparam int WW = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cfg_start = 1'b0;
  logic          cfg_bit = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [WW-1:0] wr_data;
  logic          cfg_mode;
  logic          done;
  logic          error;

  int tests = 0;
  int fails = 0;

  logic [35:0]   exp_q[$];
  logic [WW-1:0] frame_w[NW];

  config_loader #(.NWORDS(NW), .WORDW(WW), .SYNC(8'hA5)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .cfg_start (cfg_start),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cfg_mode  (cfg_mode),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every write the DUT presents must match the next expectation.
  always @(negedge clock) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {28'd0, wr_addr, wr_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e[35:32]));
        chk("wr_data", 64'(wr_data), 64'(e[31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit rnd);
    if (rnd) begin
      for (int s = 0; s < 8 && $urandom_range(1, 0) == 1; s++) begin
        cfg_valid = 1'b0;
        cfg_bit   = 1'($urandom);
        tick();
      end
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [WW-1:0] w, input int nbits, input bit rnd);
    for (int i = nbits - 1; i >= 0; i--) send_bit(w[i], rnd);
  endtask

  task automatic start_pulse(input bit with_bit);
    cfg_start = 1'b1;
    cfg_valid = with_bit;
    cfg_bit   = 1'($urandom);
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  function automatic logic [WW-1:0] xor_all();
    logic [WW-1:0] x = '0;
    for (int k = 0; k < NW; k++) x ^= frame_w[k];
    return x;
  endfunction

  task automatic expect_words(input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({4'(k), frame_w[k]});
  endtask

  task automatic run_frame(input logic [WW-1:0] cs, input bit rnd, input bit noise,
                           input bit start_bit, input string tag);
    bit ok;
    ok = (cs == xor_all());
    start_pulse(start_bit);
    chk({tag, "_ready_sync"}, 64'(cfg_ready), 64'd1);
    chk({tag, "_mode_sync"}, 64'(cfg_mode), 64'd1);
    if (noise) send_bits(32'h3C, 8, rnd);
    send_bits(32'hA5, 8, rnd);
    expect_words(NW);
    for (int k = 0; k < NW; k++) send_bits(frame_w[k], WW, rnd);
    send_bits(cs, WW, rnd);
    tick();
    chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'(ok));
    chk({tag, "_error"}, 64'(error), 64'(!ok));
    chk({tag, "_cfg_mode"}, 64'(cfg_mode), 64'(!ok));
    chk({tag, "_ready_end"}, 64'(cfg_ready), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
    chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_error"}, 64'(error), 64'd0);
    chk({tag, "_cfg_mode"}, 64'(cfg_mode), 64'd1);
    chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd0);
  endtask

  task automatic random_words();
    for (int k = 0; k < NW; k++) frame_w[k] = $urandom;
  endtask

  initial begin
    #2;
    check_reset_outputs("reset");
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // Counting frame 1..15; its checksum is the XOR of the words.
    for (int k = 0; k < NW; k++) frame_w[k] = 32'(k + 1);
    run_frame(32'h0000_0000, 1'b0, 1'b0, 1'b0, "count_cs0");
    run_frame(32'h0000_0001, 1'b0, 1'b0, 1'b0, "count_cs1");

    // Noise before sync, random contents.
    random_words();
    run_frame(xor_all(), 1'b0, 1'b1, 1'b0, "noise");

    // Random stalls; start coincides with a valid bit that must be dropped.
    for (int k = 0; k < NW; k++) frame_w[k] = 32'(k + 1);
    run_frame(32'h0000_0000, 1'b1, 1'b0, 1'b1, "stall");

    // Restart after word 5 plus a partial word 6.
    random_words();
    start_pulse(1'b0);
    send_bits(32'hA5, 8, 1'b0);
    expect_words(6);
    for (int k = 0; k < 6; k++) send_bits(frame_w[k], WW, 1'b0);
    send_bits(32'hFFFF_FFFF, 12, 1'b0);
    chk("restart_partial_pending", 64'(exp_q.size()), 64'd0);
    random_words();
    run_frame(xor_all(), 1'b0, 1'b0, 1'b0, "restart");

    // Reset in the middle of word 7.
    random_words();
    start_pulse(1'b0);
    send_bits(32'hA5, 8, 1'b0);
    expect_words(7);
    for (int k = 0; k < 7; k++) send_bits(frame_w[k], WW, 1'b0);
    send_bits(frame_w[7], 10, 1'b0);
    #3 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    chk("midreset_pending", 64'(exp_q.size()), 64'd0);
    tick();
    reset_n = 1'b1;
    send_bits(32'hA5A5_A5A5, 32, 1'b0);
    send_bits(32'hA5A5_A5A5, 32, 1'b0);
    chk("idle_ready", 64'(cfg_ready), 64'd0);
    random_words();
    run_frame(xor_all() ^ 32'h0000_0100, 1'b0, 1'b0, 1'b0, "after_reset_bad");

    // Random frames with random stalls and random checksum correctness.
    for (int r = 0; r < 3; r++) begin
      random_words();
      run_frame(($urandom_range(1, 0) == 1) ? xor_all() : (xor_all() ^ 32'(1 << $urandom_range(31, 0))),
                1'b1, 1'b0, 1'($urandom), "rand");
    end

    repeat (3) tick();
    chk("final_pending", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
